instruction_dispatcher: RTL

- Sits directly downstream of the instruction queue.
- Pops one instruction at a time, decodes opcode and fields, and issues a command to the matching execution unit: host DMA, weight FIFO, matrix unit or activation unit.
- Holds issue until that unit reports completion, so instruction execution is strictly in order.

---
 rtl/instruction_dispatcher.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/instruction_dispatcher.sv
// In-order instruction dispatcher: pops one instruction, decodes it and issues a single command,
// holding until the target unit reports done. Optional PERF_CNT_EN adds retire/stall counters.
module instruction_dispatcher #(
  parameter int unsigned INSTR_W   = 32,
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned LEN_W     = 14,
  parameter int unsigned NUM_UNITS = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 iq_empty_i,
  output logic                 iq_read_o,
  input  logic [INSTR_W-1:0]   iq_instr_i,
  output logic [NUM_UNITS-1:0] cmd_valid_o,
  input  logic [NUM_UNITS-1:0] cmd_ready_i,
  output logic [ADDR_W-1:0]    cmd_addr_o,
  output logic [LEN_W-1:0]     cmd_len_o,
  input  logic [NUM_UNITS-1:0] unit_done_i,
  output logic                 busy_o,
  output logic                 halted_o,
  output logic                 err_o
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]          retired_cnt_o,
  output logic [31:0]          stall_cnt_o
`endif
);

  localparam int unsigned UnitW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  localparam logic [3:0] OpNop         = 4'd0;
  localparam logic [3:0] OpReadHost    = 4'd1;
  localparam logic [3:0] OpWriteHost   = 4'd2;
  localparam logic [3:0] OpReadWeights = 4'd3;
  localparam logic [3:0] OpMatmul      = 4'd4;
  localparam logic [3:0] OpActivate    = 4'd5;
  localparam logic [3:0] OpSync        = 4'd6;
  localparam logic [3:0] OpHalt        = 4'd7;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLatch,
    StDecode,
    StIssue,
    StWaitDone,
    StHalted
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         opcode_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   len_q;
  logic               err_q, err_d;
  logic [UnitW-1:0]   unit_idx;
  logic               sel_ready;
  logic               sel_done;

  // Target unit is a pure function of the latched opcode; only meaningful in ISSUE/WAIT_DONE.
  always_comb begin
    unit_idx = '0;
    case (opcode_q)
      OpReadHost, OpWriteHost: unit_idx = UnitW'(0);
      OpReadWeights:           unit_idx = UnitW'(1);
      OpMatmul:                unit_idx = UnitW'(2);
      OpActivate:              unit_idx = UnitW'(3);
      default:                 unit_idx = '0;
    endcase
  end

  assign sel_ready = cmd_ready_i[unit_idx];
  assign sel_done  = unit_done_i[unit_idx];

  // State and field registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= StIdle;
      opcode_q <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (state_q == StLatch) begin
        opcode_q <= iq_instr_i[INSTR_W-1 -: 4];
        addr_q   <= iq_instr_i[ADDR_W+LEN_W-1 : LEN_W];
        len_q    <= iq_instr_i[LEN_W-1:0];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle:  if (!iq_empty_i) state_d = StFetch;
      StFetch: state_d = StLatch;
      StLatch: state_d = StDecode;
      StDecode: begin
        case (opcode_q)
          OpNop, OpSync: state_d = StIdle;
          OpHalt:        state_d = StHalted;
          OpReadHost, OpWriteHost, OpReadWeights, OpMatmul, OpActivate: state_d = StIssue;
          default: begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
        endcase
      end
      StIssue:    if (sel_ready) state_d = StWaitDone;
      // done is deliberately not looked at in ISSUE
      StWaitDone: if (sel_done) state_d = StIdle;
      StHalted:   state_d = StHalted;
      default:    state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    cmd_valid_o = '0;
    if (state_q == StIssue) cmd_valid_o[unit_idx] = 1'b1;
    iq_read_o   = (state_q == StFetch);
    busy_o      = (state_q != StIdle) && (state_q != StHalted);
    halted_o    = (state_q == StHalted);
    cmd_addr_o  = addr_q;
    cmd_len_o   = len_q;
    err_o       = err_q;
  end

`ifdef PERF_CNT_EN
  logic [31:0] retired_q;
  logic [31:0] stall_q;
  logic        retire_evt;
  logic        stall_evt;

  assign retire_evt = (state_d == StIdle) &&
                      ((state_q == StDecode) || (state_q == StWaitDone));
  assign stall_evt  = (state_q == StIssue) && !sel_ready;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (retire_evt) retired_q <= retired_q + 32'd1;
      if (stall_evt)  stall_q   <= stall_q + 32'd1;
    end
  end

  assign retired_cnt_o = retired_q;
  assign stall_cnt_o   = stall_q;
`endif

endmodule
